// File: rtl/axi_default_slave_pkg.sv
// Shared AXI widths, response codes and FSM state types for the default (DECERR) slave.
package axi_default_slave_pkg;

    localparam int unsigned AXI_ADDR_WIDTH = 32;
    localparam int unsigned AXI_DATA_WIDTH = 32;

    localparam logic [1:0] AXI_RESP_OKAY   = 2'b00;
    localparam logic [1:0] AXI_RESP_DECERR = 2'b11;

    typedef enum logic [1:0] {
        W_IDLE = 2'd0,
        W_DATA = 2'd1,
        W_RESP = 2'd2
    } w_state_t;

    typedef enum logic {
        R_IDLE = 1'b0,
        R_DATA = 1'b1
    } r_state_t;

endpackage

// File: rtl/axi_default_slave.sv
// AXI4 responder for unmapped address windows: completes every write and read with DECERR.
// Write and read channels are independent FSMs, one outstanding transaction each.
module axi_default_slave
    import axi_default_slave_pkg::*;
#(
    parameter int unsigned ID_WIDTH   = 4,
    parameter int unsigned DATA_WIDTH = AXI_DATA_WIDTH
) (
    input  logic                      ACLK,
    input  logic                      ARESETn,

    input  logic [ID_WIDTH-1:0]       AWID,
    input  logic [AXI_ADDR_WIDTH-1:0] AWADDR,
    input  logic [7:0]                AWLEN,
    input  logic                      AWVALID,
    output logic                      AWREADY,

    input  logic [DATA_WIDTH-1:0]     WDATA,
    input  logic [DATA_WIDTH/8-1:0]   WSTRB,
    input  logic                      WLAST,
    input  logic                      WVALID,
    output logic                      WREADY,

    output logic [ID_WIDTH-1:0]       BID,
    output logic [1:0]                BRESP,
    output logic                      BVALID,
    input  logic                      BREADY,

    input  logic [ID_WIDTH-1:0]       ARID,
    input  logic [AXI_ADDR_WIDTH-1:0] ARADDR,
    input  logic [7:0]                ARLEN,
    input  logic                      ARVALID,
    output logic                      ARREADY,

    output logic [ID_WIDTH-1:0]       RID,
    output logic [DATA_WIDTH-1:0]     RDATA,
    output logic [1:0]                RRESP,
    output logic                      RLAST,
    output logic                      RVALID,
    input  logic                      RREADY
);

    w_state_t w_state, w_state_nxt;
    r_state_t r_state, r_state_nxt;

    logic [ID_WIDTH-1:0] bid_q;
    logic [ID_WIDTH-1:0] rid_q;
    logic [7:0]          r_cnt;

    logic aw_hs, w_last_hs, b_hs, ar_hs, r_hs;

    // Address, data and length fields are irrelevant to an error responder.
    logic unused_inputs;
    assign unused_inputs = ^{AWADDR, AWLEN, WDATA, WSTRB, ARADDR};

    // Handshakes are qualified by state-decoded ready/valid, so no input reaches an output.
    assign aw_hs     = AWVALID && AWREADY;
    assign w_last_hs = WVALID && WREADY && WLAST;
    assign b_hs      = BVALID && BREADY;
    assign ar_hs     = ARVALID && ARREADY;
    assign r_hs      = RVALID && RREADY;

    always_ff @(posedge ACLK or negedge ARESETn) begin
        if (!ARESETn) begin
            w_state <= W_IDLE;
            bid_q   <= '0;
        end else begin
            w_state <= w_state_nxt;
            if (aw_hs) bid_q <= AWID;
        end
    end

    always_comb begin
        w_state_nxt = w_state;
        AWREADY     = 1'b0;
        WREADY      = 1'b0;
        BVALID      = 1'b0;
        unique case (w_state)
            W_IDLE: begin
                AWREADY = 1'b1;
                if (aw_hs) w_state_nxt = W_DATA;
            end
            W_DATA: begin
                WREADY = 1'b1;
                if (w_last_hs) w_state_nxt = W_RESP;
            end
            W_RESP: begin
                BVALID = 1'b1;
                if (b_hs) w_state_nxt = W_IDLE;
            end
            default: w_state_nxt = W_IDLE;
        endcase
    end

    assign BID   = bid_q;
    assign BRESP = BVALID ? AXI_RESP_DECERR : AXI_RESP_OKAY;

    always_ff @(posedge ACLK or negedge ARESETn) begin
        if (!ARESETn) begin
            r_state <= R_IDLE;
            rid_q   <= '0;
            r_cnt   <= '0;
        end else begin
            r_state <= r_state_nxt;
            if (ar_hs) begin
                rid_q <= ARID;
                r_cnt <= ARLEN;
            end else if (r_hs && (r_cnt != 8'd0)) begin
                r_cnt <= r_cnt - 8'd1;
            end
        end
    end

    always_comb begin
        r_state_nxt = r_state;
        ARREADY     = 1'b0;
        RVALID      = 1'b0;
        RLAST       = 1'b0;
        unique case (r_state)
            R_IDLE: begin
                ARREADY = 1'b1;
                if (ar_hs) r_state_nxt = R_DATA;
            end
            R_DATA: begin
                RVALID = 1'b1;
                RLAST  = (r_cnt == 8'd0);
                if (r_hs && (r_cnt == 8'd0)) r_state_nxt = R_IDLE;
            end
            default: r_state_nxt = R_IDLE;
        endcase
    end

    assign RID   = rid_q;
    assign RDATA = '0;
    assign RRESP = RVALID ? AXI_RESP_DECERR : AXI_RESP_OKAY;

endmodule

// File: tb/tb_axi_default_slave.sv
// Directed self-checking bench for axi_default_slave; inputs change and outputs are sampled 1ns after each rising edge.
module tb_axi_default_slave;
    import axi_default_slave_pkg::*;

    localparam int unsigned IDW = 4;
    localparam int unsigned DW  = 32;

    logic            ACLK = 1'b0;
    logic            ARESETn;
    logic [IDW-1:0]  AWID;
    logic [31:0]     AWADDR;
    logic [7:0]      AWLEN;
    logic            AWVALID;
    logic            AWREADY;
    logic [DW-1:0]   WDATA;
    logic [DW/8-1:0] WSTRB;
    logic            WLAST;
    logic            WVALID;
    logic            WREADY;
    logic [IDW-1:0]  BID;
    logic [1:0]      BRESP;
    logic            BVALID;
    logic            BREADY;
    logic [IDW-1:0]  ARID;
    logic [31:0]     ARADDR;
    logic [7:0]      ARLEN;
    logic            ARVALID;
    logic            ARREADY;
    logic [IDW-1:0]  RID;
    logic [DW-1:0]   RDATA;
    logic [1:0]      RRESP;
    logic            RLAST;
    logic            RVALID;
    logic            RREADY;

    int total = 0;
    int bad   = 0;

    axi_default_slave #(.ID_WIDTH(IDW), .DATA_WIDTH(DW)) dut (
        .ACLK(ACLK), .ARESETn(ARESETn),
        .AWID(AWID), .AWADDR(AWADDR), .AWLEN(AWLEN), .AWVALID(AWVALID), .AWREADY(AWREADY),
        .WDATA(WDATA), .WSTRB(WSTRB), .WLAST(WLAST), .WVALID(WVALID), .WREADY(WREADY),
        .BID(BID), .BRESP(BRESP), .BVALID(BVALID), .BREADY(BREADY),
        .ARID(ARID), .ARADDR(ARADDR), .ARLEN(ARLEN), .ARVALID(ARVALID), .ARREADY(ARREADY),
        .RID(RID), .RDATA(RDATA), .RRESP(RRESP), .RLAST(RLAST), .RVALID(RVALID), .RREADY(RREADY)
    );

    always #5 ACLK = ~ACLK;

    task automatic tick();
        @(posedge ACLK);
        #1;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic chk_reset_vals(input string tag);
        chk({tag, ".awready"}, 64'(AWREADY), 64'd1);
        chk({tag, ".arready"}, 64'(ARREADY), 64'd1);
        chk({tag, ".wready"},  64'(WREADY),  64'd0);
        chk({tag, ".bvalid"},  64'(BVALID),  64'd0);
        chk({tag, ".rvalid"},  64'(RVALID),  64'd0);
        chk({tag, ".rlast"},   64'(RLAST),   64'd0);
        chk({tag, ".bid"},     64'(BID),     64'd0);
        chk({tag, ".rid"},     64'(RID),     64'd0);
        chk({tag, ".bresp"},   64'(BRESP),   64'd0);
        chk({tag, ".rresp"},   64'(RRESP),   64'd0);
        chk({tag, ".rdata"},   64'(RDATA),   64'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "simulation time limit exceeded");
    end

    initial begin
        bit   wpat [0:6];
        int   beats;
        int   nbeat;
        int   nlast;
        int   last_at;
        int   cyc;

        ARESETn = 1'b0;
        AWID = '0; AWADDR = 32'h5000_0000; AWLEN = '0; AWVALID = 1'b0;
        WDATA = 32'hDEAD_BEEF; WSTRB = '1; WLAST = 1'b0; WVALID = 1'b0;
        BREADY = 1'b0;
        ARID = '0; ARADDR = 32'h8000_0000; ARLEN = '0; ARVALID = 1'b0;
        RREADY = 1'b0;

        tick();
        tick();
        chk_reset_vals("rst");
        ARESETn = 1'b1;
        tick();

        // Single-beat write
        AWID = 4'd3; AWVALID = 1'b1;
        tick();
        AWVALID = 1'b0;
        chk("w1.wready", 64'(WREADY), 64'd1);
        chk("w1.awready_low", 64'(AWREADY), 64'd0);
        WVALID = 1'b1; WLAST = 1'b1; BREADY = 1'b1;
        tick();
        WVALID = 1'b0; WLAST = 1'b0;
        chk("w1.bvalid", 64'(BVALID), 64'd1);
        chk("w1.bid", 64'(BID), 64'd3);
        chk("w1.bresp", 64'(BRESP), 64'd3);
        chk("w1.wready_low", 64'(WREADY), 64'd0);
        tick();
        BREADY = 1'b0;
        chk("w1.awready_back", 64'(AWREADY), 64'd1);
        chk("w1.bvalid_low", 64'(BVALID), 64'd0);

        // Burst write with WVALID gaps and delayed BREADY
        AWID = 4'd9; AWLEN = 8'd3; AWVALID = 1'b1;
        tick();
        AWVALID = 1'b0;
        wpat = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1};
        beats = 0;
        for (int i = 0; i < 7; i++) begin
            WVALID = wpat[i];
            WLAST  = wpat[i] && (beats == 3);
            tick();
            if (wpat[i]) beats++;
            if (beats < 4) chk("w2.wready_during", 64'(WREADY), 64'd1);
            else           chk("w2.bvalid_after_last", 64'(BVALID), 64'd1);
        end
        WVALID = 1'b0; WLAST = 1'b0;
        for (int i = 0; i < 5; i++) begin
            chk("w2.bvalid_hold", 64'(BVALID), 64'd1);
            chk("w2.bid_hold", 64'(BID), 64'd9);
            chk("w2.bresp_hold", 64'(BRESP), 64'd3);
            tick();
        end
        BREADY = 1'b1;
        tick();
        BREADY = 1'b0;
        chk("w2.bvalid_done", 64'(BVALID), 64'd0);
        chk("w2.awready_back", 64'(AWREADY), 64'd1);
        tick();
        chk("w2.single_b", 64'(BVALID), 64'd0);

        // 8-beat read burst, RREADY held high
        ARID = 4'd5; ARLEN = 8'd7; ARVALID = 1'b1; RREADY = 1'b1;
        tick();
        ARVALID = 1'b0;
        for (int i = 0; i < 8; i++) begin
            chk("r1.rvalid", 64'(RVALID), 64'd1);
            chk("r1.rid", 64'(RID), 64'd5);
            chk("r1.rresp", 64'(RRESP), 64'd3);
            chk("r1.rdata", 64'(RDATA), 64'd0);
            chk("r1.rlast", 64'(RLAST), (i == 7) ? 64'd1 : 64'd0);
            tick();
        end
        chk("r1.rvalid_done", 64'(RVALID), 64'd0);
        chk("r1.arready_back", 64'(ARREADY), 64'd1);

        // ARLEN=0 with backpressure
        ARID = 4'd2; ARLEN = 8'd0; ARVALID = 1'b1; RREADY = 1'b0;
        tick();
        ARVALID = 1'b0;
        for (int i = 0; i < 3; i++) begin
            chk("r0.rvalid_hold", 64'(RVALID), 64'd1);
            chk("r0.rlast_hold", 64'(RLAST), 64'd1);
            chk("r0.rid_hold", 64'(RID), 64'd2);
            RREADY = (i == 1);
            if (i == 1) begin
                tick();
                break;
            end
            tick();
        end
        RREADY = 1'b0;
        chk("r0.rvalid_done", 64'(RVALID), 64'd0);
        chk("r0.arready_back", 64'(ARREADY), 64'd1);

        // ARLEN=255: 256 beats, RLAST only on the last
        ARID = 4'd1; ARLEN = 8'd255; ARVALID = 1'b1; RREADY = 1'b1;
        tick();
        ARVALID = 1'b0;
        nbeat = 0; nlast = 0; last_at = 0; cyc = 0;
        while (RVALID === 1'b1 && cyc < 300) begin
            nbeat++;
            if (RLAST === 1'b1) begin
                nlast++;
                last_at = nbeat;
            end
            tick();
            cyc++;
        end
        RREADY = 1'b0;
        chk("r255.beats", 64'(nbeat), 64'd256);
        chk("r255.rlast_count", 64'(nlast), 64'd1);
        chk("r255.rlast_beat", 64'(last_at), 64'd256);
        chk("r255.arready_back", 64'(ARREADY), 64'd1);

        // Early W before AW, simultaneous AW and AR
        WVALID = 1'b1; WLAST = 1'b1;
        tick();
        chk("cc.wready_early", 64'(WREADY), 64'd0);
        AWID = 4'd6; AWVALID = 1'b1;
        ARID = 4'hA; ARLEN = 8'd1; ARVALID = 1'b1;
        chk("cc.wready_at_aw", 64'(WREADY), 64'd0);
        tick();
        AWVALID = 1'b0; ARVALID = 1'b0;
        chk("cc.wready", 64'(WREADY), 64'd1);
        chk("cc.rvalid", 64'(RVALID), 64'd1);
        chk("cc.awready_low", 64'(AWREADY), 64'd0);
        chk("cc.arready_low", 64'(ARREADY), 64'd0);
        chk("cc.rid", 64'(RID), 64'hA);
        chk("cc.rlast0", 64'(RLAST), 64'd0);
        tick();
        WVALID = 1'b0; WLAST = 1'b0;
        chk("cc.bvalid", 64'(BVALID), 64'd1);
        chk("cc.bid", 64'(BID), 64'd6);
        chk("cc.bresp", 64'(BRESP), 64'd3);
        BREADY = 1'b1; RREADY = 1'b1;
        tick();
        chk("cc.bvalid_done", 64'(BVALID), 64'd0);
        chk("cc.rvalid1", 64'(RVALID), 64'd1);
        chk("cc.rlast1", 64'(RLAST), 64'd1);
        tick();
        BREADY = 1'b0; RREADY = 1'b0;
        chk("cc.rvalid_done", 64'(RVALID), 64'd0);
        chk("cc.arready_back", 64'(ARREADY), 64'd1);
        chk("cc.awready_back", 64'(AWREADY), 64'd1);

        // Reset in the middle of a read burst and write data phase
        AWID = 4'd4; AWVALID = 1'b1;
        ARID = 4'd7; ARLEN = 8'd7; ARVALID = 1'b1; RREADY = 1'b1;
        tick();
        AWVALID = 1'b0; ARVALID = 1'b0;
        WVALID = 1'b1; WLAST = 1'b0;
        tick();
        tick();
        chk("mr.in_burst_rvalid", 64'(RVALID), 64'd1);
        chk("mr.in_burst_wready", 64'(WREADY), 64'd1);
        ARESETn = 1'b0;
        #1;
        chk_reset_vals("mr");
        WVALID = 1'b0; RREADY = 1'b0;
        tick();
        ARESETn = 1'b1;
        tick();
        chk("mr.awready_after", 64'(AWREADY), 64'd1);
        chk("mr.arready_after", 64'(ARREADY), 64'd1);
        chk("mr.rvalid_after", 64'(RVALID), 64'd0);
        chk("mr.wready_after", 64'(WREADY), 64'd0);
        chk("mr.bvalid_after", 64'(BVALID), 64'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
